// File: rtl/mant_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mant_mult_seq_ctrl
//
// Sequential shift-and-add controller for the SIZE x SIZE mantissa multiply of
// the IEEE-754 datapath. One external SIZE-bit carry adder is time-shared over
// SIZE iterations. The 2*SIZE-bit unnormalised product goes to the
// normalise/round stage.
//
// The adder lives outside this block and is purely combinational:
//   add_s = add_a + add_b, returned in the same cycle.
//
// Ports
//   clk      in   1        clock, rising edge
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        request, sampled only while idle
//   in1      in   SIZE     multiplicand, captured when start is accepted
//   in2      in   SIZE     multiplier, captured when start is accepted
//   busy     out  1        high while iterating
//   done     out  1        one-cycle completion pulse
//   product  out  2*SIZE   in1*in2, held until the next completion
//   norm     out  1        product MSB, normaliser shift select
//   add_a    out  SIZE     adder operand A (accumulator)
//   add_b    out  SIZE     adder operand B (multiplicand or zero)
//   add_s    in   SIZE+1   adder sum including carry out
//
// Build option
//   MANT_MULT_ZERO_BYPASS_EN : when defined, a start with a zero operand goes
//   straight to completion with product 0. The adder is never exercised and
//   busy stays low. When undefined, zero operands take the full iteration path.
// -----------------------------------------------------------------------------
module mant_mult_seq_ctrl #(
   parameter int unsigned SIZE = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [SIZE-1:0]     in1,
   input  logic [SIZE-1:0]     in2,
   output logic                busy,
   output logic                done,
   output logic [2*SIZE-1:0]   product,
   output logic                norm,
   output logic [SIZE-1:0]     add_a,
   output logic [SIZE-1:0]     add_b,
   input  logic [SIZE:0]       add_s
);

   localparam int unsigned CNT_W = $clog2(SIZE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [SIZE-1:0]   mcand;
   logic [SIZE-1:0]   acc;
   logic [SIZE-1:0]   mplr;
   logic [CNT_W-1:0]  cnt;
   logic              last_iter;

`ifdef MANT_MULT_ZERO_BYPASS_EN
   logic              zero_op;
   assign zero_op = (in1 == '0) || (in2 == '0);
`endif

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      add_a      = '0;
      add_b      = '0;
      last_iter  = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
`ifdef MANT_MULT_ZERO_BYPASS_EN
               if (zero_op) begin
                  state_next = DONE;
               end else begin
                  state_next = CALC;
               end
`else
               state_next = CALC;
`endif
            end
         end

         CALC: begin
            busy = 1'b1;
            // The multiplier LSB selects whether this iteration adds the
            // multiplicand. The adder otherwise adds zero to the accumulator.
            add_a = acc;
            add_b = mplr[0] ? mcand : '0;
            if (cnt == CNT_LAST) begin
               last_iter  = 1'b1;
               state_next = DONE;
            end
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath
   //
   // {acc, mplr} forms a 2*SIZE-bit shift register. Each iteration shifts it
   // right by one bit. The adder carry enters the acc MSB, and the sum LSB
   // drops into the mplr MSB, where it replaces the multiplier bit that was
   // just consumed. After SIZE iterations the register holds the full product.
   // The last iteration writes the product straight from the adder result, so
   // the product is valid in the same cycle that done rises.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         acc     <= '0;
         mplr    <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= in1;
                  mplr  <= in2;
                  acc   <= '0;
                  cnt   <= '0;
`ifdef MANT_MULT_ZERO_BYPASS_EN
                  if (zero_op) begin
                     product <= '0;
                  end
`endif
               end
            end

            CALC: begin
               acc  <= add_s[SIZE:1];
               mplr <= {add_s[0], mplr[SIZE-1:1]};
               cnt  <= cnt + CNT_W'(1);
               if (last_iter) begin
                  product <= {add_s[SIZE:1], add_s[0], mplr[SIZE-1:1]};
               end
            end

            default: begin
            end
         endcase
      end
   end

   assign norm = product[2*SIZE-1];

endmodule

// File: tb/tb_mant_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mant_mult_seq_ctrl
//
// Directed bench for mant_mult_seq_ctrl with SIZE=24. The external adder is
// modelled here as a combinational sum. Expected values are hand-computed
// constants.
//
// Latency is counted in rising edges after the edge that sampled start:
//   24 on the iterating path
//   0 on the zero-operand bypass, where done is already high right after
//     the sampling edge
// -----------------------------------------------------------------------------
module tb_mant_mult_seq_ctrl;

   localparam int unsigned SIZE = 24;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic [SIZE-1:0]     in1;
   logic [SIZE-1:0]     in2;
   logic                busy;
   logic                done;
   logic [2*SIZE-1:0]   product;
   logic                norm;
   logic [SIZE-1:0]     add_a;
   logic [SIZE-1:0]     add_b;
   logic [SIZE:0]       add_s;

   int unsigned n_cmp;
   int unsigned n_err;
   logic [2*SIZE-1:0] prev_product;

   mant_mult_seq_ctrl #(.SIZE(SIZE)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .in1     (in1),
      .in2     (in2),
      .busy    (busy),
      .done    (done),
      .product (product),
      .norm    (norm),
      .add_a   (add_a),
      .add_b   (add_b),
      .add_s   (add_s)
   );

   assign add_s = {1'b0, add_a} + {1'b0, add_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one multiply. It can check add_b on every iteration, and it can pulse
   // start again at iteration 10, which the DUT must ignore.
   task automatic run_mult(input string name, input logic [SIZE-1:0] a,
                           input logic [SIZE-1:0] b,
                           input logic [2*SIZE-1:0] exp_p, input logic exp_n,
                           input int exp_lat, input bit chk_addb,
                           input bit restart10);
      int lat;
      int nbusy;
      lat   = -1;
      nbusy = 0;
      @(negedge clk);
      in1   = a;
      in2   = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in1   = ~a;
      in2   = ~b;
      for (int c = 0; c < 60; c++) begin
         check_val({name, "_busy_done_excl"}, 64'(busy & done), 64'd0);
         if (c == 0 && !done)
            check_val({name, "_product_held"}, 64'(product), 64'(prev_product));
         if (busy) nbusy++;
         if (chk_addb && busy && c < int'(SIZE))
            check_val({name, "_add_b"}, 64'(add_b), b[c] ? 64'(a) : 64'd0);
         if (restart10 && c == 10) begin
            start = 1'b1;
            in1   = 24'h000001;
            in2   = 24'h000001;
         end
         if (restart10 && c == 11) start = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      check_val({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check_val({name, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat));
      check_val({name, "_product"}, 64'(product), 64'(exp_p));
      check_val({name, "_norm"}, 64'(norm), 64'(exp_n));
      @(negedge clk);
      check_val({name, "_done_one_cycle"}, 64'(done), 64'd0);
      check_val({name, "_idle_busy"}, 64'(busy), 64'd0);
      check_val({name, "_idle_add_a"}, 64'(add_a), 64'd0);
      check_val({name, "_idle_add_b"}, 64'(add_b), 64'd0);
      check_val({name, "_product_hold_idle"}, 64'(product), 64'(exp_p));
      prev_product = exp_p;
   endtask

   initial begin
      int ndone;
      int zlat;
      n_cmp        = 0;
      n_err        = 0;
      prev_product = '0;
      rst_n        = 1'b0;
      start        = 1'b0;
      in1          = '0;
      in2          = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_product", 64'(product), 64'd0);
      check_val("rst_norm", 64'(norm), 64'd0);
      check_val("rst_add_a", 64'(add_a), 64'd0);
      check_val("rst_add_b", 64'(add_b), 64'd0);
      rst_n = 1'b1;

      run_mult("msb_sq", 24'h800000, 24'h800000, 48'h400000000000, 1'b0, 24, 1'b0, 1'b0);
      run_mult("max_sq", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, 24, 1'b1, 1'b0);
      run_mult("three_five", 24'h000003, 24'h000005, 48'h00000000000F, 1'b0, 24, 1'b1, 1'b0);
      run_mult("restart", 24'h123456, 24'h000010, 48'h000001234560, 1'b0, 24, 1'b0, 1'b1);

      // Reset asserted at iteration 12. The DUT must go idle at once, clear
      // the product and never pulse done.
      @(negedge clk);
      in1   = 24'h800000;
      in2   = 24'h000003;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("midrst_busy", 64'(busy), 64'd0);
      check_val("midrst_done", 64'(done), 64'd0);
      check_val("midrst_product", 64'(product), 64'd0);
      check_val("midrst_norm", 64'(norm), 64'd0);
      ndone = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 2) rst_n = 1'b1;
         if (done) ndone++;
      end
      check_val("midrst_no_done", 64'(ndone), 64'd0);
      prev_product = '0;

      run_mult("after_rst", 24'hABCDEF, 24'h000002, 48'h000001579BDE, 1'b0, 24, 1'b1, 1'b0);

`ifdef MANT_MULT_ZERO_BYPASS_EN
      zlat = 0;
`else
      zlat = 24;
`endif
      run_mult("zero_op", 24'h000000, 24'hABCDEF, 48'h000000000000, 1'b0, zlat, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
